irq_arbiter: RTL and testbench

Interrupt controller that shares the CPU's single interrupt line among four memory-mapped peripherals (switches, timer, mouse, spare), each of which raises a level `SEND_INTERRUPT` held until acknowledged. It masks, arbitrates (fixed or round-robin priority), presents one winner to the CPU, and routes the CPU acknowledge back to the winning peripheral as a one-cycle pulse. It sits on the shared 8-bit data bus at base address 0xF0.

---
 rtl/irq_arbiter.sv | 129 ++++++++++++
 tb/tb_irq_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Four-source interrupt arbiter: masks peripheral levels, picks one winner (fixed or round-robin),
// raises CPU_IRQ and routes the CPU acknowledge back as a one-cycle pulse. Registers at BASE_ADDR..+2.
module irq_arbiter #(
   parameter logic [7:0] BASE_ADDR = 8'hF0
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic [3:0] IRQ_IN,
   output logic [3:0] IRQ_ACK_OUT,
   output logic       CPU_IRQ,
   input  logic       CPU_IRQ_ACK,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   inout  wire  [7:0] BUS_DATA
);

   typedef enum logic [1:0] {IDLE, GRANT, ACK, RECOVER} state_t;

   state_t     state, state_nxt;
   logic [1:0] id, id_nxt;
   logic [1:0] last_grant;
   logic [3:0] mask;
   logic       mode;
   logic [3:0] req;
   logic [1:0] fixed_win;
   logic [1:0] rr_win;
   logic       rr_found;
   logic [1:0] cand;
   logic [7:0] offset;
   logic       addr_hit;
   logic [7:0] rd_mux;
   logic       rd_en;
   logic [7:0] rd_data;

   assign req      = IRQ_IN & mask;
   assign offset   = BUS_ADDR - BASE_ADDR;
   assign addr_hit = (offset < 8'd3);

   // Both arbitration results are always computed; IDLE picks one based on MODE.
   always_comb begin
      fixed_win = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) fixed_win = 2'(i);
      end
      rr_win   = 2'd0;
      rr_found = 1'b0;
      cand     = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant + 2'(k);
         if (!rr_found && req[cand]) begin
            rr_win   = cand;
            rr_found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state      <= IDLE;
         id         <= 2'd0;
         last_grant <= 2'd3;
      end else begin
         state <= state_nxt;
         id    <= id_nxt;
         if (state == ACK) last_grant <= id;
      end
   end

   // Outputs decode from the state register so an async reset clears them at once.
   always_comb begin
      state_nxt   = state;
      id_nxt      = id;
      CPU_IRQ     = 1'b0;
      IRQ_ACK_OUT = 4'b0000;
      case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               id_nxt    = mode ? rr_win : fixed_win;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            CPU_IRQ = 1'b1;
            if (CPU_IRQ_ACK)  state_nxt = ACK;
            else if (!req[id]) state_nxt = IDLE;
         end
         ACK: begin
            IRQ_ACK_OUT = 4'b0001 << id;
            state_nxt   = RECOVER;
         end
         RECOVER: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         mask <= 4'hF;
         mode <= 1'b0;
      end else if (BUS_WE && addr_hit) begin
         if (offset[1:0] == 2'd0) mask <= BUS_DATA[3:0];
         if (offset[1:0] == 2'd2) mode <= BUS_DATA[0];
      end
   end

   always_comb begin
      rd_mux = 8'h00;
      case (offset[1:0])
         2'd0:    rd_mux = {4'b0000, mask};
         2'd1:    rd_mux = {(state != IDLE), 1'b0, id, req};
         2'd2:    rd_mux = {7'b0000000, mode};
         default: rd_mux = 8'h00;
      endcase
   end

   // Read data is captured at the address edge, so STATUS shows the pre-edge state.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rd_en   <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         rd_en   <= addr_hit && !BUS_WE;
         rd_data <= rd_mux;
      end
   end

   assign BUS_DATA = rd_en ? rd_data : 8'hzz;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: stimulus queues expected bus reads and acknowledge pulses,
// a monitor pops and compares whenever the DUT presents read data or an IRQ_ACK_OUT pulse.
module tb_irq_arbiter;

   typedef struct {
      string      name;
      logic [7:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] irq_in;
   logic [3:0] irq_ack_out;
   logic       cpu_irq;
   logic       cpu_irq_ack;
   logic [7:0] bus_addr;
   logic       bus_we;
   wire  [7:0] bus_data;
   logic       tb_drive;
   logic [7:0] tb_wdata;
   logic       rd_seen = 1'b0;

   exp_t rd_q[$];
   exp_t ack_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   assign bus_data = tb_drive ? tb_wdata : 8'hzz;

   irq_arbiter #(.BASE_ADDR(8'hF0)) dut (
      .CLK         (clk),
      .RESETN      (resetn),
      .IRQ_IN      (irq_in),
      .IRQ_ACK_OUT (irq_ack_out),
      .CPU_IRQ     (cpu_irq),
      .CPU_IRQ_ACK (cpu_irq_ack),
      .BUS_ADDR    (bus_addr),
      .BUS_WE      (bus_we),
      .BUS_DATA    (bus_data)
   );

   always #10 clk = ~clk;

   task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // A read presented at a rising edge yields data by the following falling edge.
   always @(posedge clk) begin
      rd_seen = resetn && !bus_we && (bus_addr >= 8'hF0) && (bus_addr <= 8'hF2);
   end

   always @(negedge clk) begin
      exp_t e;
      if (rd_seen) begin
         if (rd_q.size() == 0) check_output("unexpected_bus_read", bus_data, 8'h00);
         else begin
            e = rd_q.pop_front();
            check_output(e.name, bus_data, e.val);
         end
      end
      if (irq_ack_out != 4'b0000) begin
         if (ack_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_irq_ack: got 0x%01h, expected no pulse at %0t", irq_ack_out, $time);
         end else begin
            e = ack_q.pop_front();
            check_output(e.name, {4'b0000, irq_ack_out}, e.val);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] irq, input logic ack);
      irq_in      = irq;
      cpu_irq_ack = ack;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      bus_addr = addr;
      bus_we   = 1'b1;
      tb_wdata = data;
      tb_drive = 1'b1;
      step();
      bus_we   = 1'b0;
      tb_drive = 1'b0;
      bus_addr = 8'h00;
   endtask

   task automatic bus_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
      rd_q.push_back('{name, exp});
      bus_addr = addr;
      bus_we   = 1'b0;
      step();
      bus_addr = 8'h00;
   endtask

   task automatic expect_ack(input string name, input logic [3:0] vec);
      ack_q.push_back('{name, {4'b0000, vec}});
   endtask

   task automatic wait_irq(input string name, input int budget);
      for (int i = 0; i < budget && !cpu_irq; i++) step();
      check_output(name, {7'b0, cpu_irq}, 8'h01);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetn   = 1'b0;
      irq_in   = 4'b0000;
      cpu_irq_ack = 1'b0;
      bus_addr = 8'h00;
      bus_we   = 1'b0;
      tb_drive = 1'b0;
      tb_wdata = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      resetn = 1'b1;

      // Reset state
      check_output("reset_cpu_irq", {7'b0, cpu_irq}, 8'h00);
      check_output("reset_ack_out", {4'b0, irq_ack_out}, 8'h00);
      bus_read("reset_mask", 8'hF0, 8'h0F);
      bus_read("reset_mode", 8'hF2, 8'h00);
      bus_read("reset_status", 8'hF1, 8'h00);

      // Single source: grant, status, ack, drop
      apply_stimulus(4'b0001, 1'b0);
      step();
      check_output("single_irq_latency", {7'b0, cpu_irq}, 8'h01);
      bus_read("single_status", 8'hF1, 8'h81);
      expect_ack("single_ack", 4'b0001);
      apply_stimulus(4'b0001, 1'b1);
      step();
      check_output("single_irq_drop_on_ack", {7'b0, cpu_irq}, 8'h00);
      apply_stimulus(4'b0000, 1'b0);
      step();
      step();
      bus_read("single_idle_status", 8'hF1, 8'h00);

      // Fixed priority: 1010 serves ID 1 then ID 3
      apply_stimulus(4'b1010, 1'b0);
      wait_irq("fixed_irq1", 4);
      bus_read("fixed_status_id1", 8'hF1, 8'h9A);
      expect_ack("fixed_ack_id1", 4'b0010);
      apply_stimulus(4'b1010, 1'b1);
      step();
      apply_stimulus(4'b1000, 1'b0);
      wait_irq("fixed_irq3", 8);
      bus_read("fixed_status_id3", 8'hF1, 8'hB8);
      expect_ack("fixed_ack_id3", 4'b1000);
      apply_stimulus(4'b1000, 1'b1);
      step();
      apply_stimulus(4'b0000, 1'b0);
      step();
      step();

      // Round-robin with all sources held: 0,1,2,3,0,1,2,3 and a+4 re-grant latency
      bus_write(8'hF2, 8'h01);
      bus_read("rr_mode", 8'hF2, 8'h01);
      apply_stimulus(4'b1111, 1'b0);
      for (int i = 0; i < 8; i++) begin
         wait_irq("rr_irq", 8);
         bus_read("rr_status", 8'hF1, 8'h8F | {2'b00, 2'(i % 4), 4'b0000});
         expect_ack("rr_ack", 4'(1 << (i % 4)));
         apply_stimulus(4'b1111, 1'b1);
         step();
         apply_stimulus(4'b1111, 1'b0);
         check_output("rr_irq_low_in_ack", {7'b0, cpu_irq}, 8'h00);
         step();
         step();
         check_output("rr_irq_low_a3", {7'b0, cpu_irq}, 8'h00);
         step();
         check_output("rr_irq_high_a4", {7'b0, cpu_irq}, 8'h01);
      end
      // Withdrawal of the ID 0 grant must leave last_grant at 3, so 1001 picks ID 0
      apply_stimulus(4'b0000, 1'b0);
      step();
      check_output("rr_withdraw_irq", {7'b0, cpu_irq}, 8'h00);
      apply_stimulus(4'b1001, 1'b0);
      step();
      bus_read("rr_after_withdraw", 8'hF1, 8'h89);
      apply_stimulus(4'b0000, 1'b0);
      step();
      check_output("rr_withdraw2_irq", {7'b0, cpu_irq}, 8'h00);
      bus_write(8'hF2, 8'h00);

      // Mask withdraws a pending grant; restoring the mask re-grants
      apply_stimulus(4'b0100, 1'b0);
      step();
      check_output("mask_irq_grant", {7'b0, cpu_irq}, 8'h01);
      bus_write(8'hF0, 8'h0B);
      check_output("mask_irq_still_high", {7'b0, cpu_irq}, 8'h01);
      step();
      check_output("mask_irq_withdrawn", {7'b0, cpu_irq}, 8'h00);
      bus_read("mask_status", 8'hF1, 8'h20);
      bus_read("mask_value", 8'hF0, 8'h0B);
      bus_write(8'hF0, 8'hFF);
      bus_read("mask_upper_ignored", 8'hF0, 8'h0F);
      wait_irq("mask_regrant", 4);
      bus_read("mask_regrant_status", 8'hF1, 8'hA4);

      // Ack in the same cycle the source drops: ack wins
      expect_ack("ack_vs_drop", 4'b0100);
      apply_stimulus(4'b0000, 1'b1);
      step();
      check_output("ack_vs_drop_irq", {7'b0, cpu_irq}, 8'h00);
      apply_stimulus(4'b0000, 1'b0);
      step();
      step();

      // Ack while idle is ignored
      apply_stimulus(4'b0000, 1'b1);
      step();
      check_output("idle_ack_irq", {7'b0, cpu_irq}, 8'h00);
      check_output("idle_ack_out", {4'b0, irq_ack_out}, 8'h00);
      step();
      apply_stimulus(4'b0000, 1'b0);
      bus_read("idle_ack_status", 8'hF1, 8'h20);

      // Reset asserted during ACK kills the pulse and restores defaults
      bus_write(8'hF0, 8'h07);
      bus_write(8'hF2, 8'h01);
      apply_stimulus(4'b0010, 1'b0);
      step();
      check_output("rst_pre_irq", {7'b0, cpu_irq}, 8'h01);
      apply_stimulus(4'b0010, 1'b1);
      @(posedge clk);
      #1;
      check_output("rst_ack_present", {4'b0, irq_ack_out}, 8'h02);
      resetn = 1'b0;
      #1;
      check_output("rst_ack_cleared", {4'b0, irq_ack_out}, 8'h00);
      check_output("rst_irq_cleared", {7'b0, cpu_irq}, 8'h00);
      apply_stimulus(4'b0000, 1'b0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      bus_read("rst_mask", 8'hF0, 8'h0F);
      bus_read("rst_mode", 8'hF2, 8'h00);
      bus_read("rst_status", 8'hF1, 8'h00);
      bus_write(8'hF2, 8'h01);
      apply_stimulus(4'b1001, 1'b0);
      step();
      bus_read("rst_last_grant", 8'hF1, 8'h89);
      apply_stimulus(4'b0000, 1'b0);
      step();
      check_output("rst_final_irq", {7'b0, cpu_irq}, 8'h00);

      repeat (3) step();
      check_output("rd_q_drained", 8'(rd_q.size()), 8'h00);
      check_output("ack_q_drained", 8'(ack_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
